// File: rtl/clk_mon_pkg.sv
// Shared state encoding and sizing constants for the divided-clock monitor.
package clk_mon_pkg;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2,
        STALLED = 2'd3
    } state_t;

    localparam int ERR_CNT_W  = 8;
    localparam int SYNC_DEPTH = 2;

endpackage

// File: rtl/clk_edge_sync.sv
// Brings the divided clock into the fast domain as data and emits one-cycle
// rise/fall enables from the synchronized level and a one-flop history.
module clk_edge_sync
    import clk_mon_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic clk_div,
    output logic rise,
    output logic fall
);

    logic [SYNC_DEPTH-1:0] sync;
    logic                  hist;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync <= '0;
            hist <= 1'b0;
        end else begin
            sync <= {sync[SYNC_DEPTH-2:0], clk_div};
            hist <= sync[SYNC_DEPTH-1];
        end
    end

    // Edge enables are combinational from the last two synchronized samples.
    assign rise = sync[SYNC_DEPTH-1] & ~hist;
    assign fall = ~sync[SYNC_DEPTH-1] & hist;

endmodule

// File: rtl/divided_clock_monitor.sv
// Period/lock/stall checker for a divided clock sampled in the fast domain.
// Optional high-time check is enabled by defining CLKMON_DUTY_CHECK_EN.
module divided_clock_monitor
    import clk_mon_pkg::*;
#(
    parameter  int DIV      = 8,
    parameter  int LOCK_CNT = 2,
    parameter  int TIMEOUT  = 2 * DIV,
    localparam int CW       = $clog2(TIMEOUT) + 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 clk_div_in,
    output logic                 rise_pulse,
    output logic                 fall_pulse,
    output logic [CW-1:0]        period,
    output logic                 locked,
    output logic                 stall,
    output logic                 error,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam int GW = $clog2(LOCK_CNT + 1);

    state_t          state, state_next;
    logic [CW-1:0]   cnt;
    logic [GW-1:0]   good_cnt, good_next;
    logic [CW-1:0]   period_next;
    logic            locked_next;
    logic            stall_next;
    logic            err_next;
    logic            duty_bad;

    function automatic logic [CW-1:0] cnt_sat_inc(input logic [CW-1:0] v);
        return (v == {CW{1'b1}}) ? v : v + 1'b1;
    endfunction

    function automatic logic [ERR_CNT_W-1:0] err_sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (v == {ERR_CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    clk_edge_sync u_sync (
        .clock   (clock),
        .reset   (reset),
        .clk_div (clk_div_in),
        .rise    (rise_pulse),
        .fall    (fall_pulse)
    );

    always_comb begin
        state_next  = state;
        good_next   = good_cnt;
        period_next = period;
        locked_next = locked;
        stall_next  = stall;
        err_next    = 1'b0;
        duty_bad    = 1'b0;
`ifdef CLKMON_DUTY_CHECK_EN
        duty_bad    = fall_pulse && (cnt != CW'(DIV / 2));
`endif
        case (state)
            SEARCH: begin
                if (rise_pulse) begin
                    state_next = MEASURE;
                    good_next  = '0;
                end
            end
            MEASURE, LOCKED: begin
                if (rise_pulse) begin
                    period_next = cnt;
                    if (cnt == CW'(DIV)) begin
                        if (state == MEASURE) begin
                            if (good_cnt == GW'(LOCK_CNT - 1)) begin
                                state_next  = LOCKED;
                                locked_next = 1'b1;
                                good_next   = GW'(LOCK_CNT);
                            end else begin
                                good_next = good_cnt + 1'b1;
                            end
                        end
                    end else begin
                        err_next    = 1'b1;
                        good_next   = '0;
                        locked_next = 1'b0;
                        state_next  = MEASURE;
                    end
                // A rise in the same cycle always wins over the timeout.
                end else if (cnt == CW'(TIMEOUT)) begin
                    state_next  = STALLED;
                    stall_next  = 1'b1;
                    locked_next = 1'b0;
                    good_next   = '0;
                    err_next    = 1'b1;
                end else if (duty_bad) begin
                    err_next    = 1'b1;
                    good_next   = '0;
                    locked_next = 1'b0;
                    state_next  = MEASURE;
                end
            end
            STALLED: begin
                if (rise_pulse) begin
                    state_next = MEASURE;
                    stall_next = 1'b0;
                    good_next  = '0;
                end
            end
            default: state_next = SEARCH;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= SEARCH;
            cnt       <= '0;
            good_cnt  <= '0;
            period    <= '0;
            locked    <= 1'b0;
            stall     <= 1'b0;
            error     <= 1'b0;
            err_count <= '0;
        end else begin
            state    <= state_next;
            good_cnt <= good_next;
            period   <= period_next;
            locked   <= locked_next;
            stall    <= stall_next;
            error    <= err_next;
            cnt      <= rise_pulse ? CW'(1) : cnt_sat_inc(cnt);
            if (err_next) begin
                err_count <= err_sat_inc(err_count);
            end
        end
    end

endmodule
